vpu_req_queue: RTL and testbench

VPU_REQ_QUEUE -- requirements
Module: vpu_req_queue

---
 rtl/vpu_pkg.sv | 15 +
 rtl/vpu_req_queue_if.sv | 11 +
 rtl/vpu_req_queue_mem.sv | 24 ++
 rtl/vpu_req_queue.sv | 66 ++++++
 tb/tb_vpu_req_queue.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vpu_pkg.sv
// Shared VPU request types and sizing constants for the request queue slice.
package vpu_pkg;

  localparam int VPU_OPC_W           = 8;
  localparam int VPU_ADDR_W          = 16;
  localparam int VPU_REQ_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [VPU_OPC_W-1:0]  opcode;
    logic [VPU_ADDR_W-1:0] src0;
    logic [VPU_ADDR_W-1:0] src1;
    logic [VPU_ADDR_W-1:0] dst;
  } vpu_req_t;

endpackage

// File: rtl/vpu_req_queue_if.sv
// Controller-facing request channel: queue drives valid and the head request.
interface vpu_req_queue_if;
  import vpu_pkg::*;

  logic     valid;
  vpu_req_t req;

  modport src (output valid, output req);
  modport dst (input valid, input req);

endinterface

// File: rtl/vpu_req_queue_mem.sv
// Request payload storage: one synchronous write port, one combinational read port, no reset.
module vpu_req_queue_mem
  import vpu_pkg::*;
#(
  parameter int DEPTH = VPU_REQ_QUEUE_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  vpu_req_t         wdata,
  input  logic [PTR_W-1:0] raddr,
  output vpu_req_t         rdata
);

  vpu_req_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vpu_req_queue.sv
// Host-to-controller request FIFO; status outputs come from registered state only.
module vpu_req_queue
  import vpu_pkg::*;
#(
  parameter int DEPTH = VPU_REQ_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_valid_i,
  input  vpu_req_t                 host_req_i,
  output logic                     host_ready_o,
  vpu_req_queue_if.src             req_if,
  input  logic                     req_queue_rden_i,
  input  logic                     clear_err_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     underflow_err_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             err;
  logic             push, pop, empty;

  assign empty        = (count == '0);
  assign host_ready_o = (count != CNT_FULL);
  assign req_if.valid = !empty;
  assign occupancy_o  = count;
  assign underflow_err_o = err;

  // Ready is registered-only, so a pop on a full queue frees space next cycle.
  assign push = host_valid_i && host_ready_o;
  assign pop  = req_queue_rden_i && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // A new underflow outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err <= 1'b0;
    else if (req_queue_rden_i && empty) err <= 1'b1;
    else if (clear_err_i)              err <= 1'b0;
  end

  vpu_req_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (host_req_i),
    .raddr (rd_ptr),
    .rdata (req_if.req)
  );

endmodule

// File: tb/tb_vpu_req_queue.sv
// Directed and random checks of vpu_req_queue: latency, full/empty, wrap, underflow, reset.
module tb_vpu_req_queue;
  import vpu_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     hv, rden, clr;
  vpu_req_t hreq;
  logic     hready, uerr;
  logic [2:0] occ;

  int checks = 0;
  int failures = 0;

  vpu_req_queue_if rif ();

  vpu_req_queue #(.DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .host_valid_i     (hv),
    .host_req_i       (hreq),
    .host_ready_o     (hready),
    .req_if           (rif.src),
    .req_queue_rden_i (rden),
    .clear_err_i      (clr),
    .occupancy_o      (occ),
    .underflow_err_o  (uerr)
  );

  always #5 clk = ~clk;

  function automatic vpu_req_t mk(input logic [7:0] op);
    vpu_req_t r;
    r.opcode = op;
    r.src0   = {8'h10, op};
    r.src1   = {8'h20, op};
    r.dst    = {8'h30, op};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  vpu_req_t q[$];
  logic     err_m;
  logic     m_push, m_pop;

  initial begin
    hv = 0; rden = 0; clr = 0; hreq = '0; rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_occ",   occ, 0);
    chk("rst_valid", rif.valid, 0);
    chk("rst_ready", hready, 1);
    chk("rst_err",   uerr, 0);
    rst_n = 1;

    // First push: not visible before the edge, visible after it
    hv = 1; hreq = mk(8'h01);
    #1 chk("nobypass_valid", rif.valid, 0);
    step();
    chk("lat_valid", rif.valid, 1);
    chk("lat_req",   rif.req, mk(8'h01));
    chk("lat_occ",   occ, 1);

    hreq = mk(8'h02); step();
    hreq = mk(8'h03); step();
    hreq = mk(8'h04); step();
    chk("full_occ",   occ, 4);
    chk("full_ready", hready, 0);
    chk("full_head",  rif.req, mk(8'h01));

    // Held request while full is not accepted
    hreq = mk(8'h05); step();
    chk("held_occ", occ, 4);
    chk("held_ready", hready, 0);

    // Pop on full does not admit the held push the same cycle
    rden = 1; step();
    chk("popfull_occ",   occ, 3);
    chk("popfull_head",  rif.req, mk(8'h02));
    chk("popfull_ready", hready, 1);
    rden = 0; step();
    chk("held_accept_occ", occ, 4);
    hv = 0;
    rden = 1; step();
    chk("drain_head3", rif.req, mk(8'h03));
    step();
    chk("drain_head4", rif.req, mk(8'h04));
    chk("drain_occ2",  occ, 2);

    // Steady push+pop at occupancy 2: order kept across pointer wrap
    for (int i = 0; i < 10; i++) begin
      hv = 1; rden = 1; hreq = mk(8'(6 + i));
      chk("pp_head", rif.req, (i == 0) ? mk(8'h04) : (i == 1) ? mk(8'h05) : mk(8'(4 + i)));
      step();
      chk("pp_occ", occ, 2);
    end
    hv = 0;
    chk("pp_tail0", rif.req, mk(8'h0e));
    step();
    chk("pp_tail1", rif.req, mk(8'h0f));
    step();
    chk("empty_occ",   occ, 0);
    chk("empty_valid", rif.valid, 0);

    // Underflow, clear, and clear-vs-underflow priority
    step();
    chk("uf_err", uerr, 1);
    chk("uf_occ", occ, 0);
    rden = 0; clr = 1; step();
    chk("clr_err", uerr, 0);
    rden = 1; clr = 0; step();
    chk("uf2_err", uerr, 1);
    rden = 1; clr = 1; step();
    chk("uf_wins", uerr, 1);
    rden = 0; clr = 1; step();
    chk("clr2_err", uerr, 0);
    clr = 0;

    // Empty with push and rden together: push taken, pop ignored, error set
    hv = 1; rden = 1; hreq = mk(8'h20); step();
    chk("ep_occ",  occ, 1);
    chk("ep_head", rif.req, mk(8'h20));
    chk("ep_err",  uerr, 1);
    hv = 0; rden = 0; clr = 1; step();
    chk("ep_clr", uerr, 0);
    chk("ep_occ_keep", occ, 1);
    clr = 0;

    hv = 1; hreq = mk(8'h21); step();
    hreq = mk(8'h22); step();
    hv = 0;
    chk("pre_rst_occ", occ, 3);

    // Asynchronous reset mid-cycle
    #2 rst_n = 0;
    #1;
    chk("arst_valid", rif.valid, 0);
    chk("arst_occ",   occ, 0);
    chk("arst_ready", hready, 1);
    @(negedge clk);
    rst_n = 1;
    hv = 1; hreq = mk(8'h30); step();
    hv = 0;
    chk("post_rst_occ",  occ, 1);
    chk("post_rst_head", rif.req, mk(8'h30));
    rden = 1; step();
    rden = 0;
    chk("post_rst_empty", occ, 0);

    // Random traffic against a queue model
    err_m = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      hv   = 1'($urandom_range(0, 1));
      rden = ($urandom_range(0, 9) < 4);
      clr  = ($urandom_range(0, 19) == 0);
      hreq = vpu_req_t'({$urandom, $urandom});
      m_push = hv && (q.size() != 4);
      m_pop  = rden && (q.size() != 0);
      step();
      if (rden && q.size() == 0) err_m = 1'b1;
      else if (clr)              err_m = 1'b0;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(hreq);
      chk("rnd_occ",   occ, 64'(q.size()));
      chk("rnd_valid", rif.valid, q.size() != 0);
      chk("rnd_ready", hready, q.size() != 4);
      chk("rnd_err",   uerr, err_m);
      if (q.size() != 0) chk("rnd_head", rif.req, q[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
